// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// - OE_* : bit positions in the 8-bit bus output-enable vector {EO,PO,IOH,IOL,RO,XO,YO,DO}
// - IE_* : bit positions in the 6-bit bus input-enable vector {MI,II,RI,XI,YI,DI}
// - Arbiter state encoding (CPU=0, ADDR=1, DATA=2, GAP=3)
package cpu_pkg;

  localparam int OE_EO  = 7;
  localparam int OE_PO  = 6;
  localparam int OE_IOH = 5;
  localparam int OE_IOL = 4;
  localparam int OE_RO  = 3;
  localparam int OE_XO  = 2;
  localparam int OE_YO  = 1;
  localparam int OE_DO  = 0;

  localparam int IE_MI = 5;
  localparam int IE_II = 4;
  localparam int IE_RI = 3;
  localparam int IE_XI = 2;
  localparam int IE_YI = 1;
  localparam int IE_DI = 0;

  localparam logic [1:0] ST_CPU  = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef enum logic [1:0] {
    S_CPU  = ST_CPU,
    S_ADDR = ST_ADDR,
    S_DATA = ST_DATA,
    S_GAP  = ST_GAP
  } arb_state_t;

endpackage

// File: rtl/dma_bus_arbiter_onehot_check.sv
// onehot_check: flags when more than one bit of the input vector is set.
// Ports:
//   i_vec   : vector under test
//   o_multi : 1 when popcount(i_vec) > 1
module onehot_check #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_vec,
  output logic         o_multi
);

  // Clearing the lowest set bit leaves something only if two or more were set.
  logic [W-1:0] w_low_cleared;

  assign w_low_cleared = i_vec & (i_vec - {{(W-1){1'b0}}, 1'b1});
  assign o_multi       = |w_low_cleared;

endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: shares the CPU's 16-bit bus between the microcoded CPU and
// one DMA master. DMA is granted only at an instruction boundary (cpu_rt), and
// while granted the CPU's enables are masked and T-state is frozen while the
// arbiter sequences MI (address) then RI/RO (data) cycles.
// Ports:
//   clk, reset (async, active-low)
//   cpu_oe/cpu_ie/cpu_pp/cpu_rt : CPU control decode inputs
//   bus                         : shared bus value, captured on DMA reads
//   dma_req/we/addr/wdata/last  : DMA master request interface
//   bus_oe/bus_ie/pp_out        : gated enables to the datapath
//   t_hold                      : freeze T-state counter while granted
//   dma_drive/dma_bus_val       : DMA-driven bus value
//   dma_ack/dma_rdata           : word completion and registered read data
//   dma_grant                   : DMA owns the bus
//   bus_conflict                : sticky multiple-driver flag
module dma_bus_arbiter
  import cpu_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CPU_MIN   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cpu_oe,
  input  logic [5:0]  cpu_ie,
  input  logic        cpu_pp,
  input  logic        cpu_rt,
  input  logic [15:0] bus,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  input  logic        dma_last,
  output logic [7:0]  bus_oe,
  output logic [5:0]  bus_ie,
  output logic        pp_out,
  output logic        t_hold,
  output logic        dma_drive,
  output logic [15:0] dma_bus_val,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic        dma_grant,
  output logic        bus_conflict
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = (CPU_MIN > 0) ? $clog2(CPU_MIN + 1) : 1;

  arb_state_t     r_state;
  logic [BW-1:0]  r_burst_cnt;
  logic [CW-1:0]  r_credit;
  logic [15:0]    r_rdata;
  logic           r_conflict;
  logic           w_conflict;
  logic           w_burst_full;

  assign w_burst_full = (r_burst_cnt == BW'(MAX_BURST - 1));

  // Any two of {dma_drive, bus_oe[7:0]} active together is a bus fight.
  onehot_check #(.W(9)) u_onehot_check (
    .i_vec   ({dma_drive, bus_oe}),
    .o_multi (w_conflict)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_CPU;
      r_burst_cnt <= '0;
      r_credit    <= '0;
      r_rdata     <= '0;
      r_conflict  <= 1'b0;
    end else begin
      if (w_conflict) r_conflict <= 1'b1;
      case (r_state)
        S_CPU: begin
          if (cpu_rt) begin
            if (r_credit != '0) r_credit <= r_credit - CW'(1);
            if (dma_req && (r_credit == '0)) r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          // Request withdrawn before the data cycle: abandon the word.
          r_state <= dma_req ? S_DATA : S_GAP;
        end
        S_DATA: begin
          if (r_burst_cnt != BW'(MAX_BURST)) r_burst_cnt <= r_burst_cnt + BW'(1);
          if (!dma_we) r_rdata <= bus;
          if (dma_last || !dma_req || w_burst_full) r_state <= S_GAP;
          else                                      r_state <= S_ADDR;
        end
        S_GAP: begin
          r_credit    <= CW'(CPU_MIN);
          r_burst_cnt <= '0;
          r_state     <= S_CPU;
        end
        default: r_state <= S_CPU;
      endcase
    end
  end

  always_comb begin
    bus_oe      = '0;
    bus_ie      = '0;
    pp_out      = 1'b0;
    t_hold      = 1'b1;
    dma_drive   = 1'b0;
    dma_bus_val = '0;
    dma_ack     = 1'b0;
    dma_grant   = 1'b1;
    case (r_state)
      S_CPU: begin
        bus_oe    = cpu_oe;
        bus_ie    = cpu_ie;
        pp_out    = cpu_pp;
        t_hold    = 1'b0;
        dma_grant = 1'b0;
      end
      S_ADDR: begin
        dma_drive     = 1'b1;
        dma_bus_val   = dma_addr;
        bus_ie[IE_MI] = 1'b1;
      end
      S_DATA: begin
        dma_ack = 1'b1;
        if (dma_we) begin
          dma_drive     = 1'b1;
          dma_bus_val   = dma_wdata;
          bus_ie[IE_RI] = 1'b1;
        end else begin
          bus_oe[OE_RO] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign dma_rdata    = r_rdata;
  assign bus_conflict = r_conflict;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed testbench for dma_bus_arbiter (MAX_BURST = 4, CPU_MIN = 2).
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cpu_oe;
  logic [5:0]  cpu_ie;
  logic        cpu_pp;
  logic        cpu_rt;
  logic [15:0] bus;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_last;
  logic [7:0]  bus_oe;
  logic [5:0]  bus_ie;
  logic        pp_out;
  logic        t_hold;
  logic        dma_drive;
  logic [15:0] dma_bus_val;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic        dma_grant;
  logic        bus_conflict;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dma_bus_arbiter #(.MAX_BURST(4), .CPU_MIN(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_oe       (cpu_oe),
    .cpu_ie       (cpu_ie),
    .cpu_pp       (cpu_pp),
    .cpu_rt       (cpu_rt),
    .bus          (bus),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_last     (dma_last),
    .bus_oe       (bus_oe),
    .bus_ie       (bus_ie),
    .pp_out       (pp_out),
    .t_hold       (t_hold),
    .dma_drive    (dma_drive),
    .dma_bus_val  (dma_bus_val),
    .dma_ack      (dma_ack),
    .dma_rdata    (dma_rdata),
    .dma_grant    (dma_grant),
    .bus_conflict (bus_conflict)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rt_pulse;
    cpu_rt = 1'b1;
    step;
    cpu_rt = 1'b0;
  endtask

  initial begin
    int acks;
    int gcyc;
    int k;

    reset     = 1'b0;
    cpu_oe    = '0;
    cpu_ie    = '0;
    cpu_pp    = 1'b0;
    cpu_rt    = 1'b0;
    bus       = '0;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    dma_last  = 1'b0;

    #3;
    chk("rst_grant", dma_grant, 0);
    chk("rst_thold", t_hold, 0);
    chk("rst_ack", dma_ack, 0);
    chk("rst_rdata", dma_rdata, 0);
    chk("rst_conflict", bus_conflict, 0);
    step;
    step;
    reset = 1'b1;

    // Idle: CPU enables pass straight through.
    cpu_oe = 8'h02;
    cpu_ie = 6'h04;
    cpu_pp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step;
      chk("idle_oe", bus_oe, 8'h02);
      chk("idle_ie", bus_ie, 6'h04);
      chk("idle_pp", pp_out, 1);
      chk("idle_thold", t_hold, 0);
      chk("idle_grant", dma_grant, 0);
    end

    // Single write.
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 16'h1234;
    dma_wdata = 16'hBEEF;
    dma_last  = 1'b1;
    cpu_rt    = 1'b1;
    #1;
    chk("wr_rt_oe", bus_oe, 8'h02);
    chk("wr_rt_grant", dma_grant, 0);
    step;
    cpu_rt = 1'b0;
    chk("wr_addr_grant", dma_grant, 1);
    chk("wr_addr_val", dma_bus_val, 16'h1234);
    chk("wr_addr_drive", dma_drive, 1);
    chk("wr_addr_ie", bus_ie, 6'h20);
    chk("wr_addr_oe", bus_oe, 8'h00);
    chk("wr_addr_pp", pp_out, 0);
    chk("wr_addr_thold", t_hold, 1);
    chk("wr_addr_ack", dma_ack, 0);
    step;
    chk("wr_data_val", dma_bus_val, 16'hBEEF);
    chk("wr_data_ie", bus_ie, 6'h08);
    chk("wr_data_ack", dma_ack, 1);
    chk("wr_data_oe", bus_oe, 8'h00);
    step;
    dma_req = 1'b0;
    chk("wr_gap_grant", dma_grant, 1);
    chk("wr_gap_oe", bus_oe, 8'h00);
    chk("wr_gap_ie", bus_ie, 6'h00);
    chk("wr_gap_drive", dma_drive, 0);
    chk("wr_gap_ack", dma_ack, 0);
    step;
    chk("wr_cpu_thold", t_hold, 0);
    chk("wr_cpu_grant", dma_grant, 0);
    chk("wr_cpu_oe", bus_oe, 8'h02);

    // Forced release; credit is 2 after the previous tenure.
    dma_req  = 1'b1;
    dma_last = 1'b0;
    rt_pulse;
    chk("rel_rt1_grant", dma_grant, 0);
    rt_pulse;
    chk("rel_rt2_grant", dma_grant, 0);
    rt_pulse;
    chk("rel_rt3_grant", dma_grant, 1);
    acks = 0;
    gcyc = 0;
    k    = 0;
    while (dma_grant && k < 30) begin
      if (dma_ack) acks++;
      gcyc++;
      step;
      k++;
    end
    chk("rel_acks", acks, 4);
    chk("rel_len", gcyc, 9);
    chk("rel_end_grant", dma_grant, 0);
    dma_req = 1'b0;

    // Read.
    rt_pulse;
    rt_pulse;
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_last = 1'b1;
    rt_pulse;
    chk("rd_addr_grant", dma_grant, 1);
    step;
    bus = 16'h5A5A;
    #1;
    chk("rd_data_oe", bus_oe, 8'h08);
    chk("rd_data_drive", dma_drive, 0);
    chk("rd_data_ie", bus_ie, 6'h00);
    chk("rd_data_ack", dma_ack, 1);
    step;
    bus     = 16'h0000;
    dma_req = 1'b0;
    chk("rd_rdata", dma_rdata, 16'h5A5A);
    chk("rd_gap_grant", dma_grant, 1);
    step;
    chk("rd_cpu_grant", dma_grant, 0);
    chk("rd_rdata_hold", dma_rdata, 16'h5A5A);
    chk("rd_conflict", bus_conflict, 0);

    // Abort during ADDR.
    rt_pulse;
    rt_pulse;
    dma_req = 1'b1;
    dma_we  = 1'b1;
    rt_pulse;
    chk("ab_addr_grant", dma_grant, 1);
    dma_req = 1'b0;
    #1;
    chk("ab_addr_ack", dma_ack, 0);
    step;
    chk("ab_gap_ack", dma_ack, 0);
    chk("ab_gap_grant", dma_grant, 1);
    chk("ab_gap_drive", dma_drive, 0);
    step;
    chk("ab_cpu_grant", dma_grant, 0);

    // Reset during DATA.
    rt_pulse;
    rt_pulse;
    dma_req = 1'b1;
    rt_pulse;
    step;
    chk("rs_data_ack", dma_ack, 1);
    dma_req = 1'b0;
    reset   = 1'b0;
    #1;
    chk("rs_grant", dma_grant, 0);
    chk("rs_ack", dma_ack, 0);
    chk("rs_thold", t_hold, 0);
    chk("rs_rdata", dma_rdata, 0);
    chk("rs_oe", bus_oe, 8'h02);
    step;
    reset = 1'b1;

    // Sticky conflict.
    cpu_oe = 8'h82;
    step;
    chk("cf_set", bus_conflict, 1);
    cpu_oe = 8'h02;
    step;
    step;
    chk("cf_sticky", bus_conflict, 1);
    reset = 1'b0;
    #1;
    chk("cf_reset", bus_conflict, 0);
    step;
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
